// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Samples the registered line mid-bit and reports each word with a one-cycle valid or frame-error pulse.
module serial_frame_rx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_d,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_parity_err,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic             d_q;
    logic [2:0]       state_q, state_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic [IDX_W-1:0] idx_q, idx_next;
    logic [WIDTH-1:0] shift_q, shift_next;
    logic             par_q, par_next;
    logic             perr_q, perr_next;
    logic             valid_next, ferr_next;
    logic             tick;

    // Every sampling state counts from 0; START waits half a bit, the rest a full bit.
    assign tick = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q + 1'b1;
        idx_next   = idx_q;
        shift_next = shift_q;
        par_next   = par_q;
        perr_next  = perr_q;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_next = '0;
                if (!d_q) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_next = '0;
                    idx_next = '0;
                    par_next = 1'b0;
                    state_next = d_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_next   = '0;
                    shift_next = (shift_q >> 1) | (WIDTH'(d_q) << (WIDTH - 1));
                    par_next   = par_q ^ d_q;
                    idx_next   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        perr_next  = 1'b0;
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_next   = '0;
                    perr_next  = par_q ^ d_q;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_next = '0;
                    if (d_q) begin
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (d_q) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            d_q          <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            d_q          <= i_d;
            state_q      <= state_next;
            cnt_q        <= cnt_next;
            idx_q        <= idx_next;
            shift_q      <= shift_next;
            par_q        <= par_next;
            perr_q       <= perr_next;
            o_valid      <= valid_next;
            o_parity_err <= valid_next & perr_q & (PARITY_EN != 0);
            o_frame_err  <= ferr_next;
            o_busy       <= (state_next != IDLE);
            if (valid_next) begin
                o_data <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=8, CLKS_PER_BIT=4, even parity).
// A negedge monitor stamps every valid / frame-error pulse with its cycle number.
module tb_serial_frame_rx;

    localparam int WIDTH = 8;
    localparam int C     = 4;
    localparam int LAT   = 44;  // drive of start bit to visible o_valid: 1 (d_q) + 43

    logic             clk = 1'b0;
    logic             rst;
    logic             d;
    logic [WIDTH-1:0] data;
    logic             valid, perr, ferr, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int busy_cnt = 0;

    int               vcyc_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] vdata_q[$];
    logic             vperr_q[$];
    logic             vbusy_prev_q[$];
    logic             vbusy_q[$];
    int               fcyc_q[$];
    logic             busy_prev = 1'b0;

    serial_frame_rx #(.WIDTH(WIDTH), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_d(d),
        .o_data(data), .o_valid(valid), .o_parity_err(perr),
        .o_frame_err(ferr), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("excl_valid_ferr", {31'd0, valid & ferr}, 32'd0);
            check("perr_unqualified", {31'd0, ~valid & perr}, 32'd0);
        end
        if (busy === 1'b1) busy_cnt++;
        if (valid === 1'b1) begin
            vcyc_q.push_back(cyc);
            vdata_q.push_back(data);
            vperr_q.push_back(perr);
            vbusy_prev_q.push_back(busy_prev);
            vbusy_q.push_back(busy);
        end
        if (ferr === 1'b1) fcyc_q.push_back(cyc);
        busy_prev = busy;
    end

    task automatic drive_bit(input logic b);
        d = b;
        repeat (C) @(negedge clk);
    endtask

    // Returns on the negedge of the cycle where o_valid / o_frame_err should be visible.
    task automatic send_frame(input logic [WIDTH-1:0] w, input logic flip_par,
                              input logic stop, output int t_start);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) drive_bit(w[i]);
        drive_bit((^w) ^ flip_par);
        drive_bit(stop);
    endtask

    task automatic check_valid(input string tag, input int t_start,
                               input logic [WIDTH-1:0] w, input logic exp_perr);
        int c;
        logic [WIDTH-1:0] dv, ev;
        logic pe, bp, b;
        check({tag, "_count"}, vcyc_q.size(), 32'd1);
        if (vcyc_q.size() > 0) begin
            c = vcyc_q.pop_front(); dv = vdata_q.pop_front(); pe = vperr_q.pop_front();
            bp = vbusy_prev_q.pop_front(); b = vbusy_q.pop_front();
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : w;
            check({tag, "_cycle"}, c, t_start + LAT);
            check({tag, "_data"}, dv, ev);
            check({tag, "_perr"}, pe, exp_perr);
            check({tag, "_busy_before"}, bp, 1'b1);
            check({tag, "_busy_drop"}, b, 1'b0);
        end
    endtask

    int t, t1, t2, b0;

    initial begin
        rst = 1'b1;
        d   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_perr", perr, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        b0 = busy_cnt;
        repeat (100) @(negedge clk);
        check("idle_busy", busy_cnt - b0, 32'd0);
        check("idle_valid", vcyc_q.size(), 32'd0);
        check("idle_ferr", fcyc_q.size(), 32'd0);
        check("idle_data", data, 8'h00);

        // Good frame, correct even parity
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, t);
        repeat (4) @(negedge clk);
        check_valid("a5", t, 8'hA5, 1'b0);

        // Parity bit flipped
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1, t);
        repeat (4) @(negedge clk);
        check_valid("a5_badpar", t, 8'hA5, 1'b1);

        // Stop bit low, line held low: frame error then BREAK
        send_frame(8'h3C, 1'b0, 1'b0, t);
        repeat (20) @(negedge clk);
        check("brk_ferr_count", fcyc_q.size(), 32'd1);
        if (fcyc_q.size() > 0) check("brk_ferr_cycle", fcyc_q.pop_front(), t + LAT);
        check("brk_no_valid", vcyc_q.size(), 32'd0);
        check("brk_data_held", data, 8'hA5);
        check("brk_busy", busy, 1'b1);
        d = 1'b1;
        repeat (4) @(negedge clk);
        check("brk_release_busy", busy, 1'b0);

        // One-cycle glitch
        d = 1'b0;
        @(negedge clk);
        d = 1'b1;
        @(negedge clk);
        check("glitch_busy_high", busy, 1'b1);
        repeat (2) @(negedge clk);
        check("glitch_busy_low", busy, 1'b0);
        repeat (60) @(negedge clk);
        check("glitch_no_valid", vcyc_q.size(), 32'd0);
        check("glitch_no_ferr", fcyc_q.size(), 32'd0);

        // Back-to-back frames, then reset in the middle of a third
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        send_frame(8'h01, 1'b0, 1'b1, t1);
        send_frame(8'hFF, 1'b0, 1'b1, t2);
        check("b2b_gap", t2 - t1, LAT);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("b2b_count", vcyc_q.size(), 32'd2);
        if (vcyc_q.size() == 2) begin
            check("b2b_first_cycle", vcyc_q[0], t1 + LAT);
            check("b2b_first_data", vdata_q[0], exp_q[0]);
            check("b2b_second_cycle", vcyc_q[1], t2 + LAT);
            check("b2b_second_data", vdata_q[1], exp_q[1]);
        end
        vcyc_q.delete(); vdata_q.delete(); vperr_q.delete();
        vbusy_prev_q.delete(); vbusy_q.delete(); exp_q.delete();

        rst = 1'b1;
        d   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        b0 = busy_cnt;
        repeat (60) @(negedge clk);
        check("mid_rst_quiet_valid", vcyc_q.size(), 32'd0);
        check("mid_rst_quiet_ferr", fcyc_q.size(), 32'd0);
        check("mid_rst_quiet_busy", busy_cnt - b0, 32'd0);

        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, t);
        repeat (4) @(negedge clk);
        check_valid("post_rst_5a", t, 8'h5A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
